// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor:
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - prediction mode selectors (BP_BIMODAL / BP_GSHARE)
//   - ctr_update(): saturating increment (taken) / decrement (not taken)
// ----------------------------------------------------------------------------
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] WNT = 2'b01;  // weakly not-taken (reset value)
    localparam logic [1:0] WT  = 2'b10;  // weakly taken
    localparam logic [1:0] ST  = 2'b11;  // strongly taken

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Move a 2-bit counter one step toward the observed outcome, clamping
    // at the ends so a single anomaly cannot flip a strong prediction.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr,
                                              input logic       taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// ----------------------------------------------------------------------------
// branch_predictor_if
// Bundles the fetch-side lookup, the resolution-side update and the
// redirect/statistics outputs of the branch predictor.
//   master : pipeline side (drives if_pc and upd_*, consumes predictions)
//   slave  : predictor side
//
// Handshake: the update channel is valid-only. When upd_valid is 1 the
// predictor consumes every upd_* field on that rising edge; there is no
// ready, the predictor always accepts. At most one update per cycle.
// The lookup channel has no handshake: predictions are a pure function of
// if_pc and the registered tables.
// ----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16
);
    localparam int IDX_W = $clog2(ENTRIES);

    // lookup
    logic [DATA_WIDTH-1:0] if_pc;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;
    logic [IDX_W-1:0]      pred_idx;

    // update
    logic                  upd_valid;
    logic [DATA_WIDTH-1:0] upd_pc;
    logic [IDX_W-1:0]      upd_idx;
    logic                  upd_is_branch;
    logic                  upd_is_jump;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] upd_target;
    logic                  upd_pred_taken;
    logic [DATA_WIDTH-1:0] upd_pred_target;

    // redirect and statistics
    logic                  mispredict;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [31:0]           stat_branches;
    logic [31:0]           stat_mispredicts;

    modport master (
        output if_pc,
        input  pred_taken, pred_target, pred_idx,
        output upd_valid, upd_pc, upd_idx, upd_is_branch, upd_is_jump,
               upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  mispredict, redirect_pc, stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc,
        output pred_taken, pred_target, pred_idx,
        input  upd_valid, upd_pc, upd_idx, upd_is_branch, upd_is_jump,
               upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output mispredict, redirect_pc, stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/btb_array.sv
// ----------------------------------------------------------------------------
// btb_array
// Direct-mapped branch target buffer storage: valid / tag / target per entry.
// Ports:
//   clk, rst          clock, synchronous active-high reset (valid bits only)
//   rd_idx            async read index -> rd_valid, rd_tag, rd_target
//   wr_en/idx/tag/target   sync write, sets the valid bit
//   inv_en/idx/tag    sync invalidate, clears valid only if the stored tag
//                     equals inv_tag (so an alias never kills a live entry)
// ----------------------------------------------------------------------------
module btb_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int IDX_W      = $clog2(ENTRIES),
    parameter int TAG_W      = DATA_WIDTH - IDX_W - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_target,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_target,
    input  logic                  inv_en,
    input  logic [IDX_W-1:0]      inv_idx,
    input  logic [TAG_W-1:0]      inv_tag
);

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_d    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    logic [DATA_WIDTH-1:0] target_d [ENTRIES];

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
        end else if (inv_en && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag)) begin
            valid_d[inv_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tags and targets are meaningless while their valid bit is clear, so
    // they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
// Dynamic next-PC predictor: direct-mapped BTB plus a table of 2-bit
// saturating counters, indexed bimodally or gshare-style (PC ^ history).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bp         branch_predictor_if.slave: lookup (if_pc -> pred_*), update
//              (upd_*), redirect (mispredict, redirect_pc), statistics
// Lookup is combinational from registered state; updates land on the edge
// and are seen by lookups from the next cycle (no same-cycle bypass).
// ----------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int PRED_MODE  = BP_BIMODAL,
    parameter int GHR_WIDTH  = 4
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    // ---------------- state ----------------
    logic [1:0]           pht_q [ENTRIES];
    logic [1:0]           pht_d [ENTRIES];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [31:0]          stat_br_q, stat_br_d;
    logic [31:0]          stat_mp_q, stat_mp_d;

    // ---------------- lookup ----------------
    logic [IDX_W-1:0]      lk_btb_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic [IDX_W-1:0]      lk_pht_idx;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0] rd_target;
    logic                  lk_hit;

    assign lk_btb_idx = bp.if_pc[IDX_W+1:2];
    assign lk_tag     = bp.if_pc[DATA_WIDTH-1:IDX_W+2];

    always_comb begin
        lk_pht_idx = lk_btb_idx;
        if (PRED_MODE == BP_GSHARE) lk_pht_idx = lk_btb_idx ^ IDX_W'(ghr_q);
    end

    assign lk_hit         = rd_valid && (rd_tag == lk_tag);
    assign bp.pred_idx    = lk_pht_idx;
    assign bp.pred_taken  = lk_hit && pht_q[lk_pht_idx][1];
    assign bp.pred_target = bp.pred_taken ? rd_target : bp.if_pc + DATA_WIDTH'(4);

    // ---------------- resolution ----------------
    logic                  is_jump;
    logic                  is_branch;
    logic                  actual_taken;
    logic [IDX_W-1:0]      upd_btb_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  btb_wr;
    logic                  btb_inv;

    // A jump wins if both class bits are set.
    assign is_jump      = bp.upd_is_jump;
    assign is_branch    = bp.upd_is_branch && !bp.upd_is_jump;
    assign actual_taken = (is_branch && bp.upd_taken) || is_jump;
    assign upd_btb_idx  = bp.upd_pc[IDX_W+1:2];
    assign upd_tag      = bp.upd_pc[DATA_WIDTH-1:IDX_W+2];

    // A non-control instruction predicted taken also yields actual=0 vs
    // pred=1, so the aliasing case needs no extra term here.
    assign bp.mispredict  = bp.upd_valid &&
                            ((actual_taken != bp.upd_pred_taken) ||
                             (actual_taken && (bp.upd_target != bp.upd_pred_target)));
    assign bp.redirect_pc = actual_taken ? bp.upd_target : bp.upd_pc + DATA_WIDTH'(4);

    // Not-taken branches never allocate; only taken branches and jumps write.
    assign btb_wr  = bp.upd_valid && actual_taken;
    assign btb_inv = bp.upd_valid && !is_branch && !is_jump && bp.upd_pred_taken;

    btb_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (ENTRIES),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (lk_btb_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .wr_en     (btb_wr),
        .wr_idx    (upd_btb_idx),
        .wr_tag    (upd_tag),
        .wr_target (bp.upd_target),
        .inv_en    (btb_inv),
        .inv_idx   (upd_btb_idx),
        .inv_tag   (upd_tag)
    );

    // ---------------- next state ----------------
    always_comb begin
        pht_d     = pht_q;
        ghr_d     = ghr_q;
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (bp.upd_valid) begin
            if (is_branch) begin
                pht_d[bp.upd_idx] = ctr_update(pht_q[bp.upd_idx], bp.upd_taken);
                // Shift in the newest outcome at bit 0; the cast drops the MSB.
                if (PRED_MODE == BP_GSHARE) ghr_d = GHR_WIDTH'({ghr_q, bp.upd_taken});
            end else if (is_jump) begin
                pht_d[bp.upd_idx] = ST;
            end
            if ((is_branch || is_jump) && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
            if (bp.mispredict && (stat_mp_q != '1))          stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= WNT;
            ghr_q     <= '0;
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            pht_q     <= pht_d;
            ghr_q     <= ghr_d;
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
// Drives a bimodal instance (dut0) and a gshare instance (dut1), both
// ENTRIES = 16, with the same directed then random stimulus, and compares
// every output each cycle against an array-based model of the predictor.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.DATA_WIDTH(32), .ENTRIES(16)) bif0 ();
    branch_predictor_if #(.DATA_WIDTH(32), .ENTRIES(16)) bif1 ();

    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .PRED_MODE(0), .GHR_WIDTH(4))
        dut0 (.clk(clk), .rst(rst), .bp(bif0));
    branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .PRED_MODE(1), .GHR_WIDTH(4))
        dut1 (.clk(clk), .rst(rst), .bp(bif1));

    // ---------------- bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Index 0 = bimodal instance, 1 = gshare instance.
    logic        m_valid [2][16];
    logic [31:0] m_tag   [2][16];
    logic [31:0] m_tgt   [2][16];
    int          m_pht   [2][16];
    int          m_ghr   [2];
    logic [31:0] m_sb    [2];
    logic [31:0] m_sm    [2];

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic int m_idx(input int d, input logic [31:0] pc);
        int b;
        b = slot(pc);
        if (d == 1) b = b ^ m_ghr[1];
        return b;
    endfunction

    function automatic logic m_taken(input int d, input logic [31:0] pc);
        int b;
        b = slot(pc);
        return m_valid[d][b] && (m_tag[d][b] == (pc >> 6)) && (m_pht[d][m_idx(d, pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input int d, input logic [31:0] pc);
        return m_taken(d, pc) ? m_tgt[d][slot(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset(input int d);
        for (int i = 0; i < 16; i++) begin
            m_valid[d][i] = 1'b0;
            m_tag[d][i]   = '0;
            m_tgt[d][i]   = '0;
            m_pht[d][i]   = 1;
        end
        m_ghr[d] = 0;
        m_sb[d]  = '0;
        m_sm[d]  = '0;
    endtask

    // ---------------- stimulus state ----------------
    logic [31:0] s_pc, s_upc, s_tgt, s_uptgt;
    logic        s_uv, s_isb, s_isj, s_tk, s_upt;
    int          s_idx [2];

    function automatic logic s_actual();
        return (s_isb && s_tk) || s_isj;
    endfunction

    function automatic logic s_mis();
        return s_uv && ((s_actual() != s_upt) || (s_actual() && (s_tgt != s_uptgt)));
    endfunction

    task automatic m_update(input int d);
        logic jmp, br;
        int   b;
        if (rst) begin
            m_reset(d);
        end else if (s_uv) begin
            jmp = s_isj;
            br  = s_isb && !s_isj;
            b   = slot(s_upc);
            if ((br || jmp) && m_sb[d] != 32'hFFFF_FFFF) m_sb[d] = m_sb[d] + 1;
            if (s_mis() && m_sm[d] != 32'hFFFF_FFFF)     m_sm[d] = m_sm[d] + 1;
            if (br) begin
                if (s_tk) m_pht[d][s_idx[d]] = (m_pht[d][s_idx[d]] == 3) ? 3 : m_pht[d][s_idx[d]] + 1;
                else      m_pht[d][s_idx[d]] = (m_pht[d][s_idx[d]] == 0) ? 0 : m_pht[d][s_idx[d]] - 1;
                if (s_tk) begin
                    m_valid[d][b] = 1'b1;
                    m_tag[d][b]   = s_upc >> 6;
                    m_tgt[d][b]   = s_tgt;
                end
                if (d == 1) m_ghr[1] = ((m_ghr[1] << 1) | int'(s_tk)) % 16;
            end else if (jmp) begin
                m_valid[d][b] = 1'b1;
                m_tag[d][b]   = s_upc >> 6;
                m_tgt[d][b]   = s_tgt;
                m_pht[d][s_idx[d]] = 3;
            end else if (s_upt) begin
                if (m_valid[d][b] && m_tag[d][b] == (s_upc >> 6)) m_valid[d][b] = 1'b0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic isb, input logic isj, input logic tk,
                         input logic [31:0] tgt, input logic upt, input logic [31:0] uptgt);
        s_pc = pc; s_uv = uv; s_upc = upc; s_isb = isb; s_isj = isj; s_tk = tk;
        s_tgt = tgt; s_upt = upt; s_uptgt = uptgt;
        // upd_idx is what fetch would have captured for this PC.
        s_idx[0] = m_idx(0, upc);
        s_idx[1] = m_idx(1, upc);
        bif0.if_pc = s_pc;          bif1.if_pc = s_pc;
        bif0.upd_valid = s_uv;      bif1.upd_valid = s_uv;
        bif0.upd_pc = s_upc;        bif1.upd_pc = s_upc;
        bif0.upd_idx = 4'(s_idx[0]); bif1.upd_idx = 4'(s_idx[1]);
        bif0.upd_is_branch = s_isb; bif1.upd_is_branch = s_isb;
        bif0.upd_is_jump = s_isj;   bif1.upd_is_jump = s_isj;
        bif0.upd_taken = s_tk;      bif1.upd_taken = s_tk;
        bif0.upd_target = s_tgt;    bif1.upd_target = s_tgt;
        bif0.upd_pred_taken = s_upt;    bif1.upd_pred_taken = s_upt;
        bif0.upd_pred_target = s_uptgt; bif1.upd_pred_target = s_uptgt;
    endtask

    task automatic idle(input logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // ---------------- per-cycle compare ----------------
    task automatic compare_all();
        logic        a_pt, a_mis;
        logic [31:0] a_ptg, a_rd, a_sb, a_sm;
        logic [3:0]  a_idx;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                a_pt = bif0.pred_taken; a_ptg = bif0.pred_target; a_idx = bif0.pred_idx;
                a_mis = bif0.mispredict; a_rd = bif0.redirect_pc;
                a_sb = bif0.stat_branches; a_sm = bif0.stat_mispredicts;
            end else begin
                a_pt = bif1.pred_taken; a_ptg = bif1.pred_target; a_idx = bif1.pred_idx;
                a_mis = bif1.mispredict; a_rd = bif1.redirect_pc;
                a_sb = bif1.stat_branches; a_sm = bif1.stat_mispredicts;
            end
            chk($sformatf("d%0d pred_taken pc=%0h", d, s_pc), 32'(a_pt), 32'(m_taken(d, s_pc)));
            chk($sformatf("d%0d pred_target pc=%0h", d, s_pc), a_ptg, m_target(d, s_pc));
            chk($sformatf("d%0d pred_idx pc=%0h", d, s_pc), 32'(a_idx), 32'(m_idx(d, s_pc)));
            chk($sformatf("d%0d mispredict", d), 32'(a_mis), 32'(s_mis()));
            if (s_uv)
                chk($sformatf("d%0d redirect_pc", d), a_rd, s_actual() ? s_tgt : s_upc + 32'd4);
            chk($sformatf("d%0d stat_branches", d), a_sb, m_sb[d]);
            chk($sformatf("d%0d stat_mispredicts", d), a_sm, m_sm[d]);
        end
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        m_update(0);
        m_update(1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
        if ($urandom_range(0, 15) == 0) p = $urandom() & 32'hFFFF_FFFC;
        return p;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = 32'h20;
            1:       t = 32'h200;
            2:       t = 32'h1000;
            default: t = $urandom() & 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        m_reset(0);
        m_reset(1);
        rst = 1'b1;
        idle(32'h100);
        advance();
        advance();
        rst = 1'b0;

        // Reset state.
        idle(32'h100);
        settle();
        chk("lit reset pred_taken", 32'(bif0.pred_taken), 32'h0);
        chk("lit reset pred_target", bif0.pred_target, 32'h104);
        chk("lit reset stat_branches", bif0.stat_branches, 32'h0);
        chk("lit reset stat_mispredicts", bif0.stat_mispredicts, 32'h0);
        advance();

        // First taken branch 0x40 -> 0x20, predicted not-taken.
        drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        settle();
        chk("lit train pred_taken same cycle", 32'(bif0.pred_taken), 32'h0);
        chk("lit train mispredict", 32'(bif0.mispredict), 32'h1);
        chk("lit train redirect_pc", bif0.redirect_pc, 32'h20);
        advance();

        idle(32'h40);
        settle();
        chk("lit trained pred_taken", 32'(bif0.pred_taken), 32'h1);
        chk("lit trained pred_target", bif0.pred_target, 32'h20);
        chk("lit gshare pred_idx ghr=0001", 32'(bif1.pred_idx), 32'h1);
        advance();

        // Same index, different tag.
        idle(32'h440);
        settle();
        chk("lit tag miss pred_taken", 32'(bif0.pred_taken), 32'h0);
        chk("lit tag miss pred_target", bif0.pred_target, 32'h444);
        advance();

        // Jump training from a fresh reset.
        rst = 1'b1;
        idle(32'h0);
        advance();
        rst = 1'b0;
        drive(32'h0, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h84);
        settle();
        advance();
        idle(32'h80);
        settle();
        chk("lit jal pred_taken", 32'(bif0.pred_taken), 32'h1);
        chk("lit jal pred_target", bif0.pred_target, 32'h200);
        advance();
        drive(32'h0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200);
        settle();
        chk("lit predicted branch mispredict", 32'(bif0.mispredict), 32'h0);
        advance();
        idle(32'h80);
        settle();
        chk("lit stat_branches after jal+branch", bif0.stat_branches, 32'h2);
        advance();

        // Strongly-taken branch resolving not-taken.
        rst = 1'b1;
        idle(32'h0);
        advance();
        rst = 1'b0;
        drive(32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        settle();
        advance();
        drive(32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20);
        settle();
        advance();
        drive(32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20);
        settle();
        chk("lit not-taken mispredict", 32'(bif0.mispredict), 32'h1);
        chk("lit not-taken redirect_pc", bif0.redirect_pc, 32'h44);
        advance();
        idle(32'h40);
        settle();
        chk("lit pht=2 pred_taken", 32'(bif0.pred_taken), 32'h1);
        chk("lit pht=2 pred_target", bif0.pred_target, 32'h20);
        advance();

        // Reset coincident with an update: update discarded, GHR cleared.
        rst = 1'b1;
        drive(32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        advance();
        rst = 1'b0;
        idle(32'h40);
        settle();
        chk("lit gshare pred_idx after rst", 32'(bif1.pred_idx), 32'h0);
        chk("lit gshare stat_branches after rst", bif1.stat_branches, 32'h0);
        chk("lit gshare stat_mispredicts after rst", bif1.stat_mispredicts, 32'h0);
        advance();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] upc, tgt, uptgt;
            logic        isb, isj, upt;
            int          kind;
            rst  = ($urandom_range(0, 299) == 0);
            upc  = rand_pc();
            tgt  = rand_tgt();
            kind = $urandom_range(0, 9);
            isb  = (kind <= 5) || (kind == 8);
            isj  = (kind == 6) || (kind == 7) || (kind == 8);
            if ($urandom_range(0, 3) != 0) begin
                upt   = m_taken(0, upc);
                uptgt = m_target(0, upc);
            end else begin
                upt   = 1'($urandom_range(0, 1));
                uptgt = rand_tgt();
            end
            drive(rand_pc(), ($urandom_range(0, 4) != 0), upc, isb, isj,
                  1'($urandom_range(0, 1)), tgt, upt, uptgt);
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
